// File: rtl/riscv_ascon_perm_unit_if.sv
// riscv_ascon_perm_unit_if: Ascon state types and the permutation unit's request/writeback bundle
package riscv_ascon_perm_unit_pkg;
  typedef struct packed {
    logic [31:0] x_hi;
    logic [31:0] x_low;
  } reg_view_t;
  typedef union packed {
    reg_view_t   reg_view;
    logic [63:0] w;
  } ascon_word_t;
  typedef struct packed {
    ascon_word_t x0;
    ascon_word_t x1;
    ascon_word_t x2;
    ascon_word_t x3;
    ascon_word_t x4;
  } ascon_state_t;
endpackage

interface riscv_ascon_perm_unit_if;
  import riscv_ascon_perm_unit_pkg::*;
  logic         start_i;
  logic [3:0]   rounds_i;
  logic         flush_i;
  ascon_state_t state_i;
  ascon_state_t state_o;
  logic         we_ascon_update_o;
  logic         busy_o;
  logic         done_o;
  modport master (
    output start_i, rounds_i, flush_i, state_i,
    input  state_o, we_ascon_update_o, busy_o, done_o
  );
  modport slave (
    input  start_i, rounds_i, flush_i, state_i,
    output state_o, we_ascon_update_o, busy_o, done_o
  );
endinterface

// File: rtl/riscv_ascon_perm_unit.sv
// riscv_ascon_perm_unit: iterative Ascon permutation; ASCON_PERM_UNROLL2_EN runs two rounds per cycle
module riscv_ascon_perm_unit #(
  parameter int ROUNDS_MAX = 12
) (
  input logic clk,
  input logic rst_n,
  riscv_ascon_perm_unit_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, WB} st_e;
  st_e          st_q, st_d;
  logic [3:0]   cnt_q, cnt_d, n_eff;
  logic [319:0] s_q, s_d, r1;
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, ~r, r};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return {x0 ^ ror(x0, 19) ^ ror(x0, 28), x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x2 ^ ror(x2, 1) ^ ror(x2, 6), x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x4 ^ ror(x4, 7) ^ ror(x4, 41)};
  endfunction
  // Round index counts up to 11 as the remaining count drops to 1.
  assign n_eff = (io.rounds_i > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : io.rounds_i;
  assign r1    = ascon_round(s_q, 4'd12 - cnt_q);
`ifdef ASCON_PERM_UNROLL2_EN
  logic [319:0] r2;
  assign r2 = ascon_round(r1, 4'd13 - cnt_q);
`endif
  // Next state, round counter and permutation state; flush overrides any transition.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    unique case (st_q)
      IDLE: if (io.start_i && !io.flush_i) begin
        s_d   = io.state_i;
        cnt_d = n_eff;
        st_d  = (n_eff == 4'd0) ? WB : RUN;
      end
`ifdef ASCON_PERM_UNROLL2_EN
      RUN: begin
        s_d   = (cnt_q >= 4'd2) ? r2 : r1;
        cnt_d = (cnt_q >= 4'd2) ? cnt_q - 4'd2 : 4'd0;
        st_d  = (cnt_q <= 4'd2) ? WB : RUN;
      end
`else
      RUN: begin
        s_d   = r1;
        cnt_d = cnt_q - 4'd1;
        st_d  = (cnt_q == 4'd1) ? WB : RUN;
      end
`endif
      WB:      st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (io.flush_i) st_d = IDLE;
  end
  // State registers cleared asynchronously so reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= 4'd0;
      s_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end
  assign io.state_o           = s_q;
  assign io.busy_o            = st_q != IDLE;
  assign io.we_ascon_update_o = (st_q == WB) && !io.flush_i;
  assign io.done_o            = (st_q == WB) && !io.flush_i;
endmodule

// File: tb/tb_riscv_ascon_perm_unit.sv
// tb_riscv_ascon_perm_unit: randomized bench with a table-driven Ascon model and per-cycle compare
module tb_riscv_ascon_perm_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0, tot_cnt = 0;
  riscv_ascon_perm_unit_if io ();
  riscv_ascon_perm_unit #(.ROUNDS_MAX(12)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RL [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};

  function automatic logic [63:0] rotr(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] perm(logic [319:0] s, int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  c;
    logic [319:0] o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
    for (int k = 0; k < n; k++) begin
      int r;
      r = 12 - n + k;
      x[2] ^= 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        c = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int i = 0; i < 5; i++) x[i][b] = c[4 - i];
      end
      y = x;
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], RL[i][0]) ^ rotr(y[i], RL[i][1]);
    end
    for (int i = 0; i < 5; i++) o[319 - 64 * i -: 64] = x[i];
    return o;
  endfunction

  function automatic int lat(int n);
`ifdef ASCON_PERM_UNROLL2_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(string nm, logic [319:0] a, logic [319:0] x);
    tot_cnt++;
    if (a === x) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, a, x);
  endtask

  // Reference model: tracks the outstanding request by absolute edge number.
  int e = 0, wb_e = 0, n_m;
  bit act = 0, known = 1;
  logic [319:0] res = '0, reg_m = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 0; known = 1; reg_m = '0;
    end else begin
      e++;
      if (act && e > wb_e) begin
        act = 0; known = 1; reg_m = res;
      end else if (io.flush_i) act = 0;
      else if (!act && io.start_i) begin
        n_m = (io.rounds_i > 12) ? 12 : int'(io.rounds_i);
        act = 1; known = 0; wb_e = e + lat(n_m);
        res = perm(io.state_i, n_m);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic exp_we;
  always @(negedge clk) begin
    exp_we = rst_n && act && e == wb_e && !io.flush_i;
    chk("busy", io.busy_o, rst_n && act);
    chk("we", io.we_ascon_update_o, exp_we);
    chk("done", io.done_o, exp_we);
    if (exp_we) chk("wb_state", io.state_o, res);
    else if (known) chk("idle_state", io.state_o, reg_m);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(logic [319:0] s, logic [3:0] n);
    step();
    io.start_i = 1; io.rounds_i = n; io.state_i = s;
    step();
    io.start_i = 0;
  endtask

  task automatic wait_done(output int k, output int bc);
    k = 0; bc = io.busy_o ? 1 : 0;
    while (!io.done_o && k < 30) begin
      step(); k++;
      if (io.busy_o) bc++;
    end
    if (!io.done_o) k = -1;
  endtask

  logic [319:0] s, res12;
  logic [63:0]  w0, w1, w3, w4;
  int k, bc;
  initial begin
    io.start_i = 0; io.flush_i = 0; io.rounds_i = 0; io.state_i = '0;
    repeat (3) step();
    chk("rst_busy", io.busy_o, 0);
    chk("rst_state", io.state_o, 0);
    rst_n = 1;
    // all-zero state, one round (constant 0x4b)
    go('0, 1);
    wait_done(k, bc);
    chk("lat1", k, lat(1));
    w0 = {io.state_o.x0.reg_view.x_hi, io.state_o.x0.reg_view.x_low};
    w1 = {io.state_o.x1.reg_view.x_hi, io.state_o.x1.reg_view.x_low};
    w3 = {io.state_o.x3.reg_view.x_hi, io.state_o.x3.reg_view.x_low};
    w4 = {io.state_o.x4.reg_view.x_hi, io.state_o.x4.reg_view.x_low};
    chk("zero_x0", w0, 64'h0009_64b0_0000_004b);
    chk("zero_x1", w1, 64'h0000_0000_9600_0213);
    chk("zero_x3", w3, 64'h12e5_8000_0000_004b);
    chk("zero_x4", w4, 64'h0);
    // full p12 with busy length
    s = rnd320();
    go(s, 12);
    wait_done(k, bc);
    chk("lat12", k, lat(12));
    chk("busy12", bc, lat(12) + 1);
    res12 = io.state_o;
    // zero rounds passes state through
    go(s, 0);
    wait_done(k, bc);
    chk("lat0", k, 0);
    chk("r0_pass", io.state_o, s);
    // 15 clamps to 12
    go(s, 15);
    wait_done(k, bc);
    chk("lat15", k, lat(12));
    chk("r15_eq_12", io.state_o, res12);
    // restart during run is ignored
    go(rnd320(), 12);
    step(); step();
    io.start_i = 1; io.state_i = rnd320(); io.rounds_i = 1;
    step();
    io.start_i = 0;
    wait_done(k, bc);
    chk("lat_restart", k, lat(12) - 3);
    repeat (16) step();
    chk("no_requeue", io.busy_o, 0);
    // flush mid-run, then restart
    go(rnd320(), 12);
    repeat (4) step();
    io.flush_i = 1;
    step();
    io.flush_i = 0;
    chk("flush_idle", io.busy_o, 0);
    go(rnd320(), 12);
    wait_done(k, bc);
    chk("lat_after_flush", k, lat(12));
    // reset mid-run
    go(rnd320(), 12);
    repeat (3) step();
    rst_n = 0;
    #1;
    chk("arst_busy", io.busy_o, 0);
    chk("arst_we", io.we_ascon_update_o, 0);
    chk("arst_done", io.done_o, 0);
    chk("arst_state", io.state_o, 0);
    step();
    rst_n = 1;
    go(rnd320(), 5);
    wait_done(k, bc);
    chk("lat_after_rst", k, lat(5));
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      io.start_i  = $urandom_range(0, 3) == 0;
      io.rounds_i = 4'($urandom);
      io.flush_i  = $urandom_range(0, 29) == 0;
      io.state_i  = rnd320();
      step();
    end
    io.start_i = 0; io.flush_i = 0;
    repeat (20) step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/riscv_ascon_perm_unit.md
RISCV_ASCON_PERM_UNIT -- requirements
Module: riscv_ascon_perm_unit

Interface
REQ-001 SHALL have parameter ROUNDS_MAX, default 12, maximum permutation rounds accepted (Ascon-p12).
REQ-002 SHALL have clk  input  1  core clock; all state changes on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have start_i  input  1  request a permutation on the current register-file Ascon state.
REQ-005 SHALL have rounds_i  input  4  round count for the request; sampled only with start_i.
REQ-006 SHALL have flush_i  input  1  abort any operation in progress; no writeback.
REQ-007 SHALL have state_i  input  ascon_state_t (320)  Ascon state from the register-file Ascon read port.
REQ-008 SHALL have state_o  output  ascon_state_t (320)  permuted state to the register-file Ascon write port.
REQ-009 SHALL have we_ascon_update_o  output  1  one-cycle write strobe to the register-file Ascon update enable.
REQ-010 SHALL have busy_o  output  1  unit is occupied; decode stalls new Ascon instructions.
REQ-011 SHALL have done_o  output  1  completion pulse, coincident with we_ascon_update_o.

Function
REQ-012 SHALL form each 64-bit word xN as {xN.reg_view.x_hi, xN.reg_view.x_low}, with x_hi as bits 63:32, for both state_i and state_o.
REQ-013 SHALL implement the FSM states IDLE, RUN and WB, with IDLE as the reset state.
REQ-014 IDLE: on start_i=1 and flush_i=0, SHALL capture state_i into a 320-bit state register, load a remaining-round counter, and go to RUN; if the effective count is 0, SHALL go to WB instead.
REQ-015 Effective count SHALL be rounds_i, clamped to ROUNDS_MAX when rounds_i exceeds ROUNDS_MAX.
REQ-016 RUN: SHALL apply one Ascon round per cycle, then decrement the counter; after the last round the FSM SHALL go to WB.
REQ-017 Round index r for the k-th executed round (k=0..n-1, n = effective count) SHALL be 12-n+k; the constant ((15-r)<<4)|r SHALL be XORed into x2 bits 7:0.
REQ-018 Each round SHALL apply, in order: constant addition, then the 5-bit S-box per bit column (x0 = MSB of the column), then the linear layer.
REQ-019 Linear layer: x0^=ror19^ror28; x1^=ror61^ror39; x2^=ror1^ror6; x3^=ror10^ror17; x4^=ror7^ror41; each rotation is of the word's own pre-layer value.
REQ-020 WB: SHALL assert we_ascon_update_o=1 and done_o=1 for exactly one cycle with state_o = state register, then return to IDLE.
REQ-021 Latency: with start accepted at edge T, the WB pulse SHALL be visible in cycle T+n+1.
REQ-022 busy_o SHALL be 1 in RUN and WB and 0 in IDLE.
REQ-023 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-024 flush_i=1 in any state SHALL force IDLE at the next edge with no write strobe; flush_i SHALL win over a simultaneous start_i and over WB.
REQ-025 state_o SHALL always drive the state register; register-file writes are gated solely by we_ascon_update_o.

Reset
REQ-026 While rst_n=0, SHALL hold FSM=IDLE, counter=0, state register=0, and we_ascon_update_o=done_o=busy_o=0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no write strobe; the first start_i after rst_n rises SHALL behave normally.

Configuration
REQ-028 Macro ASCON_PERM_UNROLL2_EN: when defined, RUN SHALL execute two consecutive rounds per cycle (indices r, r+1), or a single round when one round remains; latency SHALL be ceil(n/2)+1.
REQ-029 Without ASCON_PERM_UNROLL2_EN, exactly one round per cycle (REQ-016, REQ-021).

Verification
REQ-030 All-zero state_i, rounds_i=1, start at T -> WB pulse at T+2; x4 output = 0; x0..x3 match the golden C model (constant 0x4b).
REQ-031 Random state_i, rounds_i=12 -> WB at T+13 (T+7 with ASCON_PERM_UNROLL2_EN); state_o equals the Ascon-p12 golden model; busy_o high for 13 (7) cycles.
REQ-032 rounds_i=0 -> WB at T+1 with state_o==state_i; rounds_i=15 -> identical result and timing to rounds_i=12.
REQ-033 start_i pulsed again at T+3 during a 12-round run -> ignored; exactly one WB pulse at T+13.
REQ-034 flush_i at T+5 of a 12-round run -> IDLE at T+6; we_ascon_update_o never asserted; a new start at T+8 gives correct WB at T+21.
REQ-035 rst_n low at T+4 of a run -> all outputs 0 immediately; no WB; operation after reset release is correct.
